// File: rtl/preamble_peak_detector.sv
// Strict local-maximum detector over a symmetric sample window with threshold,
// holdoff and a single-entry AXI-Stream output register that counts lost beats.
module preamble_peak_detector #(
  parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned HALF_WINDOW            = 1,
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = C_S00_AXIS_TDATA_WIDTH + 32
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic                                  s00_axis_tvalid,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic                                  s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  output logic                                  s00_axis_tready,
  input  logic                                  enable,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     preamble_detector_threshold,
  input  logic [15:0]                           holdoff_len,
  output logic                                  trigger,
  output logic                                  m00_axis_tvalid,
  output logic                                  m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  input  logic                                  m00_axis_tready,
  output logic [15:0]                           dropped_count
);

  localparam int unsigned DW     = C_S00_AXIS_TDATA_WIDTH;
  localparam int unsigned IDX_W  = 32;
  localparam int unsigned WIN    = 2 * HALF_WINDOW + 1;
  localparam int unsigned FILL_W = $clog2(WIN + 1);
  localparam int unsigned HOLD_W = 16;
  localparam int unsigned DROP_W = 16;

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_HOLDOFF} state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [DW-1:0]    value;
  } beat_t;

  // Window: entry 0 is the newest sample, entry HALF_WINDOW is the centre.
  logic [DW-1:0]     win_q [WIN];
  logic [DW-1:0]     win_d [WIN];
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              eval_q, eval_d;
  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              trig_q, trig_d;
  logic              mvalid_q, mvalid_d;
  beat_t             beat_q, beat_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              is_peak_c;
  logic              detect_c;
  logic              eval_now_c;
  logic              consume_c;
  logic [IDX_W-1:0]  centre_idx_c;
  logic              unused_c;

  assign unused_c = ^{s00_axis_tlast, s00_axis_tstrb};

  // Centre must be strictly above every other entry; ties never qualify.
  always_comb begin
    is_peak_c = 1'b1;
    for (int unsigned i = 0; i < WIN; i++) begin
      if (i != HALF_WINDOW && !(win_q[HALF_WINDOW] > win_q[i])) is_peak_c = 1'b0;
    end
  end

  // idx_q has already advanced past the newest sample in the window.
  assign centre_idx_c = idx_q - IDX_W'(HALF_WINDOW) - IDX_W'(1);
  assign eval_now_c   = eval_q & enable;
  assign consume_c    = mvalid_q & m00_axis_tready;
  assign detect_c     = eval_now_c && (state_q == ST_ARMED) && is_peak_c &&
                        (win_q[HALF_WINDOW] >= preamble_detector_threshold);

  // Next-state: window shift, fill tracking, arming/holdoff and output beat.
  always_comb begin
    win_d    = win_q;
    idx_d    = idx_q;
    fill_d   = fill_q;
    eval_d   = s00_axis_tvalid & enable;
    state_d  = state_q;
    hold_d   = hold_q;
    trig_d   = 1'b0;
    mvalid_d = mvalid_q;
    beat_d   = beat_q;
    drop_d   = drop_q;

    if (s00_axis_tvalid) begin
      win_d[0] = s00_axis_tdata;
      for (int unsigned i = 1; i < WIN; i++) win_d[i] = win_q[i-1];
      idx_d = idx_q + IDX_W'(1);
    end

    if (!enable) begin
      fill_d = '0;
    end else if (s00_axis_tvalid && fill_q < FILL_W'(WIN)) begin
      fill_d = fill_q + FILL_W'(1);
    end

    if (consume_c) mvalid_d = 1'b0;

    if (detect_c) begin
      trig_d = 1'b1;
      if (!mvalid_q || consume_c) begin
        mvalid_d = 1'b1;
        beat_d   = '{idx: centre_idx_c, value: win_q[HALF_WINDOW]};
      end else if (drop_q != {DROP_W{1'b1}}) begin
        drop_d = drop_q + DROP_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (enable && fill_d == FILL_W'(WIN)) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (detect_c && holdoff_len != '0) begin
          hold_d  = holdoff_len;
          state_d = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (eval_now_c) begin
          hold_d = hold_q - HOLD_W'(1);
          if (hold_q == HOLD_W'(1)) state_d = ST_ARMED;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enable) begin
      state_d = ST_IDLE;
      hold_d  = '0;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      for (int unsigned i = 0; i < WIN; i++) win_q[i] <= '0;
      idx_q    <= '0;
      fill_q   <= '0;
      eval_q   <= 1'b0;
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      trig_q   <= 1'b0;
      mvalid_q <= 1'b0;
      beat_q   <= '0;
      drop_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < WIN; i++) win_q[i] <= win_d[i];
      idx_q    <= idx_d;
      fill_q   <= fill_d;
      eval_q   <= eval_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
      trig_q   <= trig_d;
      mvalid_q <= mvalid_d;
      beat_q   <= beat_d;
      drop_q   <= drop_d;
    end
  end

  assign s00_axis_tready = 1'b1;
  assign trigger         = trig_q;
  assign m00_axis_tvalid = mvalid_q;
  assign m00_axis_tlast  = mvalid_q;
  assign m00_axis_tdata  = C_M00_AXIS_TDATA_WIDTH'(beat_q);
  assign dropped_count   = drop_q;

endmodule

// File: tb/tb_preamble_peak_detector.sv
// Bench for preamble_peak_detector: two instances (HALF_WINDOW 1 and 2) share
// one stimulus stream and are checked every cycle against a queue-based model.
module tb_preamble_peak_detector;

  localparam int NI = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic        enable;
  logic [31:0] thr;
  logic [15:0] hold;
  logic        m_tready;

  logic        trig_w   [NI];
  logic        mval_w   [NI];
  logic        mlast_w  [NI];
  logic        sready_w [NI];
  logic [63:0] mdata_w  [NI];
  logic [15:0] drop_w   [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  preamble_peak_detector #(.C_S00_AXIS_TDATA_WIDTH(32), .HALF_WINDOW(1)) u_h1 (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
    .s00_axis_tvalid(s_tvalid), .s00_axis_tdata(s_tdata),
    .s00_axis_tlast(1'b0), .s00_axis_tstrb(4'hF), .s00_axis_tready(sready_w[0]),
    .enable(enable), .preamble_detector_threshold(thr), .holdoff_len(hold),
    .trigger(trig_w[0]), .m00_axis_tvalid(mval_w[0]), .m00_axis_tlast(mlast_w[0]),
    .m00_axis_tdata(mdata_w[0]), .m00_axis_tready(m_tready), .dropped_count(drop_w[0]));

  preamble_peak_detector #(.C_S00_AXIS_TDATA_WIDTH(32), .HALF_WINDOW(2)) u_h2 (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
    .s00_axis_tvalid(s_tvalid), .s00_axis_tdata(s_tdata),
    .s00_axis_tlast(1'b0), .s00_axis_tstrb(4'hF), .s00_axis_tready(sready_w[1]),
    .enable(enable), .preamble_detector_threshold(thr), .holdoff_len(hold),
    .trigger(trig_w[1]), .m00_axis_tvalid(mval_w[1]), .m00_axis_tlast(mlast_w[1]),
    .m00_axis_tdata(mdata_w[1]), .m00_axis_tready(m_tready), .dropped_count(drop_w[1]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] hist [$];          // accepted samples, newest first
  int unsigned m_next_idx;        // index the next accepted sample will get
  int          m_cnt;             // samples accepted since enable/reset
  bit          m_pend;            // a sample awaits its evaluation
  int          m_hrem [NI];       // centres still suppressed by holdoff
  bit          e_trig [NI];
  bit          e_valid[NI];
  logic [63:0] e_data [NI];
  int          e_drop [NI];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist = {};
      m_next_idx = 0;
      m_cnt = 0;
      m_pend = 0;
      for (int i = 0; i < NI; i++) begin
        m_hrem[i] = 0; e_trig[i] = 0; e_valid[i] = 0; e_data[i] = '0; e_drop[i] = 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        int h, w;
        bit ok, cons, loaded;
        logic [31:0] c;
        h = i + 1;
        w = 2 * h + 1;
        ok = 0;
        loaded = 0;
        cons = e_valid[i] && m_tready;
        e_trig[i] = 0;
        if (m_pend && enable) begin
          if (m_hrem[i] > 0) begin
            m_hrem[i]--;
          end else if (m_cnt >= w) begin
            c = hist[h];
            ok = (c >= thr);
            for (int j = 0; j < w; j++)
              if (j != h && !(c > hist[j])) ok = 0;
          end
        end
        if (ok) begin
          e_trig[i] = 1;
          if (!e_valid[i] || cons) begin
            e_valid[i] = 1;
            e_data[i]  = {32'(m_next_idx - 1 - h), c};
            loaded = 1;
          end else if (e_drop[i] < 16'hFFFF) begin
            e_drop[i]++;
          end
          m_hrem[i] = hold;
        end
        if (!loaded && cons) e_valid[i] = 0;
        if (!enable) m_hrem[i] = 0;
      end
      if (s_tvalid) begin
        hist.push_front(s_tdata);
        if (hist.size() > 20) hist.pop_back();
        m_next_idx++;
        if (enable && m_cnt < 100) m_cnt++;
      end
      m_pend = s_tvalid && enable;
      if (!enable) m_cnt = 0;
    end
  end

  // ---------------- per-cycle compare + observation ----------------
  int          obs_cnt  [NI];
  logic [63:0] obs_first[NI];
  logic [63:0] obs_last [NI];

  task automatic clear_obs();
    for (int i = 0; i < NI; i++) begin
      obs_cnt[i] = 0; obs_first[i] = '0; obs_last[i] = '0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("h%0d_trigger", i + 1), 64'(trig_w[i]), 64'(e_trig[i]));
        chk($sformatf("h%0d_tvalid", i + 1), 64'(mval_w[i]), 64'(e_valid[i]));
        chk($sformatf("h%0d_tlast", i + 1), 64'(mlast_w[i]), 64'(e_valid[i]));
        chk($sformatf("h%0d_tdata", i + 1), mdata_w[i], e_data[i]);
        chk($sformatf("h%0d_dropped", i + 1), 64'(drop_w[i]), 64'(e_drop[i]));
        chk($sformatf("h%0d_tready", i + 1), 64'(sready_w[i]), 64'd1);
        if (trig_w[i]) begin
          if (obs_cnt[i] == 0) obs_first[i] = mdata_w[i];
          obs_last[i] = mdata_w[i];
          obs_cnt[i]++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [31:0] v);
    s_tvalid = 1'b1;
    s_tdata  = v;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_obs();
  endtask

  task automatic send_list(input logic [31:0] vals [$]);
    foreach (vals[k]) send(vals[k]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; enable = 1'b0;
    thr = '0; hold = '0; m_tready = 1'b1;
    clear_obs();
    repeat (2) @(posedge clk);
    #1;
    // reset values
    chk("rst_tready", 64'(sready_w[1]), 64'd1);
    chk("rst_tvalid", 64'(mval_w[1]), 64'd0);
    chk("rst_tdata", mdata_w[1], 64'd0);
    chk("rst_dropped", 64'(drop_w[1]), 64'd0);

    // T1: single peak, HALF_WINDOW=2, latency pinned on the decisive sample
    enable = 1'b1; thr = 32'd8; hold = 16'd0;
    do_reset();
    send_list('{32'd0, 32'd1, 32'd5, 32'd9, 32'd5, 32'd1});
    chk("t1_h2_trig_before", 64'(trig_w[1]), 64'd0);
    send(32'd0);
    chk("t1_h2_trig_latency", 64'(trig_w[1]), 64'd1);
    idle(3);
    chk("t1_h2_count", 64'(obs_cnt[1]), 64'd1);
    chk("t1_h2_beat", obs_last[1], {32'd3, 32'd9});
    chk("t1_model_beat", e_data[1], {32'd3, 32'd9});
    chk("t1_h2_dropped", 64'(drop_w[1]), 64'd0);

    // T2: plateau and sub-threshold peak never detect
    do_reset();
    send_list('{32'd0, 32'd1, 32'd9, 32'd9, 32'd1, 32'd0, 32'd0, 32'd1, 32'd7, 32'd1, 32'd0});
    idle(3);
    chk("t2_h1_count", 64'(obs_cnt[0]), 64'd0);
    chk("t2_h2_count", 64'(obs_cnt[1]), 64'd0);
    chk("t2_h2_tvalid", 64'(mval_w[1]), 64'd0);

    // T3: holdoff suppresses the middle peak
    thr = 32'd1; hold = 16'd3;
    do_reset();
    send_list('{32'd0, 32'd5, 32'd0, 32'd6, 32'd0, 32'd7, 32'd0});
    idle(3);
    chk("t3_h1_count", 64'(obs_cnt[0]), 64'd2);
    chk("t3_h1_first", obs_first[0], {32'd1, 32'd5});
    chk("t3_h1_last", obs_last[0], {32'd5, 32'd7});

    // T4: backpressure holds the first beat and counts the rest as dropped
    hold = 16'd0; m_tready = 1'b0;
    do_reset();
    send_list('{32'd0, 32'd5, 32'd0, 32'd0, 32'd6, 32'd0, 32'd0, 32'd7, 32'd0, 32'd0});
    idle(2);
    chk("t4_h1_count", 64'(obs_cnt[0]), 64'd3);
    chk("t4_h1_dropped", 64'(drop_w[0]), 64'd2);
    chk("t4_h1_held", mdata_w[0], {32'd1, 32'd5});
    chk("t4_h1_tvalid_held", 64'(mval_w[0]), 64'd1);
    m_tready = 1'b1;
    idle(1);
    chk("t4_h1_tvalid_fall", 64'(mval_w[0]), 64'd0);

    // T5: asynchronous mid-stream reset, then refill before detecting again
    m_tready = 1'b0;
    do_reset();
    send_list('{32'd0, 32'd9, 32'd0});
    idle(2);
    chk("t5_h1_pending", 64'(mval_w[0]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_tvalid", 64'(mval_w[0]), 64'd0);
    chk("t5_async_tdata", mdata_w[0], 64'd0);
    chk("t5_async_dropped", 64'(drop_w[0]), 64'd0);
    chk("t5_async_tready", 64'(sready_w[0]), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_tready = 1'b1;
    clear_obs();
    send_list('{32'd9, 32'd0, 32'd0, 32'd4, 32'd0});
    idle(3);
    chk("t5_h1_count", 64'(obs_cnt[0]), 64'd1);
    chk("t5_h1_beat", obs_last[0], {32'd3, 32'd4});

    // T6: enable dropped between the halves of a peak
    do_reset();
    send_list('{32'd0, 32'd1, 32'd9});
    enable = 1'b0;
    idle(1);
    enable = 1'b1;
    send_list('{32'd1, 32'd0, 32'd0, 32'd0});
    idle(3);
    chk("t6_h1_count", 64'(obs_cnt[0]), 64'd0);
    chk("t6_h2_count", 64'(obs_cnt[1]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/preamble_peak_detector.md
# preamble_peak_detector

Parametrised local-maximum detector for the BPSK receive chain. It sits on the correlator magnitude stream and flags each sample that is a strict peak over a configurable symmetric window and is at or above a runtime threshold. Each detection raises a one-cycle trigger and emits the peak's sample index and value on an AXI-Stream master. A programmable holdoff suppresses repeat detections, and overflow of the output beat is counted.

## Interface
- C_S00_AXIS_TDATA_WIDTH, 32: input sample width; unsigned magnitude.
- HALF_WINDOW, 1: neighbours checked on each side; window = 2·HALF_WINDOW+1 samples; legal 1..8.
- C_M00_AXIS_TDATA_WIDTH, C_S00_AXIS_TDATA_WIDTH+32: output beat = {index[31:0], peak value}.
- s00_axis_aclk  in  1  sole clock, rising edge.
- s00_axis_aresetn  in  1  asynchronous, active-low reset.
- s00_axis_tvalid  in  1  sample valid.
- s00_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  sample.
- s00_axis_tlast, s00_axis_tstrb  in  1, C_S00_AXIS_TDATA_WIDTH/8  ignored.
- s00_axis_tready  out  1  constant 1; samples are never stalled.
- enable  in  1  detection enable.
- preamble_detector_threshold  in  C_S00_AXIS_TDATA_WIDTH  minimum peak value, inclusive.
- holdoff_len  in  16  samples suppressed after a detection.
- trigger  out  1  one-cycle detection pulse.
- m00_axis_tvalid, m00_axis_tlast  out  1  beat valid; tlast = tvalid.
- m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  {index, value}.
- m00_axis_tready  in  1  downstream ready.
- dropped_count  out  16  saturating count of lost detections.

## Operation
- An accepted sample is s00_axis_tvalid=1 at a rising edge. Each accepted sample shifts into a 2·HALF_WINDOW+1 register window and increments a 32-bit sample index. The index starts at 0 and wraps.
- The centre sample c is eligible when all of the following hold:
  - it is unsigned strictly greater than every other window entry (ties and plateaus never detect);
  - it is ≥ the threshold;
  - the window is full;
  - the state is ARMED.
- Fill counter: counts accepted samples up to 2·HALF_WINDOW+1. It clears on reset and while enable=0.
- States:
  - IDLE: entered on reset or when enable=0. Moves to ARMED once enable=1 and the fill counter reaches full.
  - ARMED: an eligible centre causes a detection. If holdoff_len=0, stay in ARMED; otherwise load the holdoff counter with holdoff_len and move to HOLDOFF.
  - HOLDOFF: the counter decrements per accepted sample. The next holdoff_len centres are ineligible. Return to ARMED when the counter reaches 0.
  - enable=0 in any state forces IDLE next cycle and drops any pending evaluation.
- Detection:
  - trigger=1 for exactly one cycle.
  - If the output register is empty, or is being consumed in the same cycle (m00_axis_tvalid & m00_axis_tready), load {index of c, value of c}.
  - Otherwise keep the held beat, discard the new one and increment dropped_count. dropped_count saturates at 0xFFFF.
  - trigger fires regardless of output backpressure.
- The output beat is held stable while m00_axis_tvalid=1 and m00_axis_tready=0.
- Threshold and holdoff_len are sampled in the evaluation cycle; mid-stream changes take effect on the next evaluation.

## Timing
- Reset values: trigger 0, m00_axis_tvalid 0, m00_axis_tdata 0, m00_axis_tlast 0, dropped_count 0, window 0, index 0, state IDLE. s00_axis_tready is 1 in and out of reset.
- Sample c+HALF_WINDOW accepted at edge E. The window and its evaluation are registered, so trigger and m00_axis_tvalid rise at edge E+1. Latency: 1 cycle after the decisive sample.
- Exactly one evaluation per accepted sample. Idle cycles (tvalid=0) never re-trigger.
- Back-to-back accepted samples sustain one evaluation per cycle.
- Reset asserted mid-operation clears all state immediately (asynchronous). Any pending beat is lost and is not counted as dropped.
- Index wrap: a 0xFFFFFFFF → 0 index transition is legal; the peak index is reported modulo 2^32.

## Test plan
- HALF_WINDOW=2, threshold=8, enable=1, samples 0,1,5,9,5,1,0 → trigger one cycle after sample index 5 is accepted; beat {index=3, value=9}; dropped_count=0.
- Same setup, plateau 0,1,9,9,1,0 and sub-threshold peak 0,1,7,1,0 → no trigger, no beat.
- HALF_WINDOW=1, threshold=1, holdoff_len=3, samples 0,5,0,6,0,7,0 → detections at index 1 and 5 only; the index-3 peak is suppressed.
- HALF_WINDOW=1, m00_axis_tready=0, three separated qualifying peaks → first beat held stable, trigger pulses 3 times, dropped_count=2. Then raise tready: the first beat is consumed and tvalid falls.
- Mid-stream, assert aresetn=0 for 2 cycles → outputs reset asynchronously. After release, no detection occurs until 2·HALF_WINDOW+1 new samples are accepted; the index restarts at 0.
- Drop enable for 1 cycle between the rising and falling halves of a qualifying peak → no detection; the window refills before re-arming.
